// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation select, the mul/div op select and the mul/div FSM.
// Latency: n/a. Backpressure: n/a.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic md_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative mul/div engine: one shift-add or restoring-subtract step per cycle on operand magnitudes.
// Latency: done in cycle DATA_WIDTH+2 after accept (2 for divide-by-zero). Backpressure: start ignored while busy.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  start,
  input  logic [1:0]            op,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_zero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   acc;
  logic [W-1:0]     opnd;
  md_op_t           op_q;
  logic             neg_q, neg_r, dz;

  md_op_t         op_in;
  logic           accept, in_signed, in_div;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     add_sum, shifted, diff;
  logic [2*W-1:0] acc_step;
  logic [W-1:0]   res_hi, res_lo;

  assign op_in     = md_op_t'(op);
  assign accept    = start && (state == ST_IDLE);
  assign in_signed = md_is_signed(op_in);
  assign in_div    = md_is_div(op_in);
  assign a_mag     = (in_signed && a[W-1]) ? (~a + 1'b1) : a;
  assign b_mag     = (in_signed && b[W-1]) ? (~b + 1'b1) : b;
  assign busy      = (state != ST_IDLE);

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
  always_comb begin
    add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    shifted  = {acc[2*W-1:W], acc[W-1]};
    diff     = shifted - {1'b0, opnd};
    acc_step = {add_sum, acc[W-1:1]};
    if (md_is_div(op_q)) begin
      if (!diff[W]) acc_step = {diff[W-1:0], acc[W-2:0], 1'b1};
      else          acc_step = {shifted[W-1:0], acc[W-2:0], 1'b0};
    end
  end

  always_comb begin
    {res_hi, res_lo} = acc;
    if (!dz) begin
      if (!md_is_div(op_q)) begin
        if (neg_q) {res_hi, res_lo} = ~acc + 1'b1;
      end else begin
        res_lo = neg_q ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        res_hi = neg_r ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= MD_MULT;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            neg_q <= in_signed && (a[W-1] ^ b[W-1]);
            neg_r <= in_signed && a[W-1];
            cnt   <= '0;
            if (in_div && (b == '0)) begin
              dz    <= 1'b1;
              acc   <= {a, {W{1'b1}}};
              opnd  <= '0;
              state <= ST_FIN;
            end else begin
              dz    <= 1'b0;
              acc   <= {{W{1'b0}}, (in_div ? a_mag : b_mag)};
              opnd  <= in_div ? b_mag : a_mag;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(W - 1)) state <= ST_FIN;
        end
        ST_FIN: begin
          hi       <= res_hi;
          lo       <= res_lo;
          div_zero <= dz;
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Single-cycle ALU plus a sequential mul/div engine sharing the same operand inputs.
// Latency: ALU combinational, mul/div as muldiv_seq. Backpressure: md_start ignored while md_busy.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            alu_ctrl,
  input  logic                  md_start,
  input  logic [1:0]            md_op,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  zero_flag,
  output logic                  ovf_flag,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_zero
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0]       sum, dif;
  logic [SHAMT_W-1:0] shamt;

  assign sum   = a + b;
  assign dif   = a - b;
  assign shamt = a[SHAMT_W-1:0];

  always_comb begin
    alu_out  = '0;
    ovf_flag = 1'b0;
    case (alu_ctrl)
      ALU_AND:  alu_out = a & b;
      ALU_OR:   alu_out = a | b;
      ALU_XOR:  alu_out = a ^ b;
      ALU_NOR:  alu_out = ~(a | b);
      ALU_ADD: begin
        alu_out  = sum;
        ovf_flag = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        alu_out  = dif;
        ovf_flag = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
      end
      ALU_SLT:  alu_out = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_out = {{(W-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_out = b << shamt;
      ALU_SRL:  alu_out = b >> shamt;
      ALU_SRA:  alu_out = $signed(b) >>> shamt;
      ALU_LUI:  alu_out = b << (W / 2);
      default:  alu_out = '0;
    endcase
  end

  assign zero_flag = (alu_out == '0);

  muldiv_seq #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .start    (md_start),
    .op       (md_op),
    .busy     (md_busy),
    .done     (md_done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed vector bench for alu_muldiv at DATA_WIDTH=32: ALU table, mul/div table, then
// hand-written sequences for busy-start, back-to-back and reset-abort behaviour.
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk, rst;
  logic [31:0] a, b;
  logic [3:0]  alu_ctrl;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] alu_out, hi, lo;
  logic        zero_flag, ovf_flag, md_busy, md_done, div_zero;

  int n_vec = 0;
  int n_err = 0;

  alu_muldiv #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .alu_ctrl  (alu_ctrl),
    .md_start  (md_start),
    .md_op     (md_op),
    .alu_out   (alu_out),
    .zero_flag (zero_flag),
    .ovf_flag  (ovf_flag),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } alu_vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } md_vec_t;

  alu_vec_t alu_tab[$];
  md_vec_t  md_tab[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launches one mul/div op and waits for md_done; poke>0 injects a start while busy at that cycle.
  task automatic run_md(input md_vec_t v, input int idx, input int poke);
    int cyc;
    md_op    = v.op;
    a        = v.a;
    b        = v.b;
    md_start = 1'b1;
    tick();
    cyc      = 1;
    md_start = 1'b0;
    a        = $urandom;
    b        = $urandom;
    while (!md_done && cyc < 60) begin
      if (cyc == poke) begin
        md_start = 1'b1;
        md_op    = 2'b11;
        a        = 32'd100;
        b        = 32'd7;
      end else begin
        md_start = 1'b0;
      end
      tick();
      cyc++;
    end
    md_start = 1'b0;
    chk($sformatf("md%0d_latency", idx), 64'(cyc), 64'(v.lat));
    chk($sformatf("md%0d_hi", idx), 64'(hi), 64'(v.hi));
    chk($sformatf("md%0d_lo", idx), 64'(lo), 64'(v.lo));
    chk($sformatf("md%0d_div_zero", idx), 64'(div_zero), 64'(v.dz));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!md_done && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dones;

    alu_tab.push_back(alu_vec_t'{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1});
    alu_tab.push_back(alu_vec_t'{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1});
    alu_tab.push_back(alu_vec_t'{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1});
    alu_tab.push_back(alu_vec_t'{ALU_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1});
    alu_tab.push_back(alu_vec_t'{ALU_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_NOR,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SLT,  32'h00000001, 32'h80000000, 32'h00000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SLT,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SLTU, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SLL,  32'h00000004, 32'h00000001, 32'h00000010, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SLL,  32'h0000001F, 32'h00000003, 32'h80000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SLL,  32'h00000024, 32'h00000001, 32'h00000010, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SRL,  32'h00000004, 32'hF0000000, 32'h0F000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SRA,  32'h00000004, 32'hF0000000, 32'hFF000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_SRA,  32'h00000004, 32'h70000000, 32'h07000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{ALU_LUI,  32'h00000000, 32'hABCD1234, 32'h12340000, 1'b0});
    alu_tab.push_back(alu_vec_t'{4'b0101,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    alu_tab.push_back(alu_vec_t'{4'b1111,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0});

    md_tab.push_back(md_vec_t'{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b11, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 2});
    md_tab.push_back(md_vec_t'{2'b01, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 34});
    md_tab.push_back(md_vec_t'{2'b11, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1, 2});
    md_tab.push_back(md_vec_t'{2'b10, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 34});

    rst      = 1'b1;
    a        = '0;
    b        = '0;
    alu_ctrl = '0;
    md_start = 1'b0;
    md_op    = '0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_done", 64'(md_done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);

    foreach (alu_tab[i]) begin
      alu_ctrl = alu_tab[i].ctrl;
      a        = alu_tab[i].a;
      b        = alu_tab[i].b;
      #2;
      chk($sformatf("alu%0d_out", i), 64'(alu_out), 64'(alu_tab[i].res));
      chk($sformatf("alu%0d_ovf", i), 64'(ovf_flag), 64'(alu_tab[i].ovf));
      chk($sformatf("alu%0d_zero", i), 64'(zero_flag), 64'(alu_tab[i].res == 32'd0));
    end

    tick();
    foreach (md_tab[i]) run_md(md_tab[i], i, 0);

    // A start pulsed mid-operation must neither disturb the result nor launch a second op.
    run_md(md_vec_t'{2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34}, 100, 5);
    tick();
    tick();
    tick();
    chk("busy_start_ignored", 64'(md_busy), 64'd0);
    chk("hold_hi", 64'(hi), 64'd0);
    chk("hold_lo", 64'(lo), 64'd15);

    // Back-to-back: md_start held across md_done.
    md_op    = 2'b01;
    a        = 32'd6;
    b        = 32'd7;
    md_start = 1'b1;
    tick();
    wait_done(cyc);
    chk("b2b_first_latency", 64'(cyc), 64'd34);
    chk("b2b_first_lo", 64'(lo), 64'd42);
    a = 32'd9;
    b = 32'd9;
    tick();
    md_start = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    chk("b2b_no_gap_busy", 64'(md_busy), 64'd1);
    wait_done(cyc);
    chk("b2b_second_latency", 64'(cyc), 64'd34);
    chk("b2b_second_hi", 64'(hi), 64'd0);
    chk("b2b_second_lo", 64'(lo), 64'd81);
    tick();

    // Reset 10 cycles into a divide aborts it silently and clears the result.
    md_op    = 2'b11;
    a        = 32'd100;
    b        = 32'd7;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (md_done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_busy", 64'(md_busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);

    // Reset wins over a simultaneous start from idle.
    rst      = 1'b1;
    md_start = 1'b1;
    md_op    = 2'b01;
    a        = 32'd1;
    b        = 32'd1;
    tick();
    rst      = 1'b0;
    md_start = 1'b0;
    chk("rst_over_start_busy", 64'(md_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
